// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with format tagging, illegal-opcode counting
// and a two-entry skid buffer so in_ready comes straight from a flop.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned FMT_W = 3;
    localparam bit          IS64  = (XLEN == 64);

    localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
    localparam logic [FMT_W-1:0] FMT_Z   = 3'd6;
    localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [FMT_W-1:0] fmt;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           dec;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, pop;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    // Raw 32-bit sign-extended immediates; widened to XLEN by signed casts.
    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};

    always_comb begin
        dec         = '0;
        dec.fmt     = FMT_R;
        dec.imm     = '0;
        dec.illegal = 1'b0;
        case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_Z;
                    dec.imm = IS64 ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'(imm_i);
                end
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'(imm_i);
            end
            7'b1110011: begin
                if (funct3[2]) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(in_inst[19:15]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'(imm_i);
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'(imm_s);
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'(imm_b);
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'(imm_u);
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'(imm_j);
            end
            7'b0110011: begin
                dec.fmt = FMT_R;
                dec.imm = '0;
            end
            7'b0111011: begin
                dec.fmt     = IS64 ? FMT_R : FMT_ILL;
                dec.illegal = !IS64;
            end
            7'b0011011: begin
                if (!IS64) begin
                    dec.fmt     = FMT_ILL;
                    dec.illegal = 1'b1;
                end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(in_inst[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'(imm_i);
                end
            end
            default: begin
                dec.fmt     = FMT_ILL;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_q && out_ready;

    // Skid-buffer next state; flush wins over any same-cycle accept or pop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = dec;
                    end
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        state_d = ST_FULL;
                        skid_d  = dec;
                    end else if (accept && pop) begin
                        main_d  = dec;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // Counter sees every delivered illegal, including one popped during flush.
    always_comb begin
        cnt_d = cnt_q;
        if (pop && main_q.illegal && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32, XLEN=64 and a 2-bit counter instance share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;

    logic        r32, v32, il32;
    logic [31:0] imm32;
    logic [2:0]  f32;
    logic [15:0] c32;

    logic        r64, v64, il64;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic [15:0] c64;

    logic        rc2, vc2, ilc2;
    logic [31:0] immc2;
    logic [2:0]  fc2;
    logic [1:0]  cc2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_inst(in_inst), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(f32), .out_illegal(il32), .illegal_cnt(c32));

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_inst(in_inst), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(f64), .out_illegal(il64), .illegal_cnt(c64));

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) uc2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rc2),
        .in_inst(in_inst), .out_valid(vc2), .out_ready(out_ready), .out_imm(immc2),
        .out_fmt(fc2), .out_illegal(ilc2), .illegal_cnt(cc2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                           input logic [2:0] ef);
        chk({tag, ".v32"}, 64'(v32), 64'd1);
        chk({tag, ".v64"}, 64'(v64), 64'd1);
        chk({tag, ".imm32"}, 64'(imm32), 64'(e32));
        chk({tag, ".imm64"}, imm64, e64);
        chk({tag, ".fmt32"}, 64'(f32), 64'(ef));
        chk({tag, ".fmt64"}, 64'(f64), 64'(ef));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".v"}, 64'({v32, v64, vc2}), 64'd0);
        chk({tag, ".rdy"}, 64'({r32, r64, rc2}), 64'd7);
        chk({tag, ".imm32"}, 64'(imm32), 64'd0);
        chk({tag, ".imm64"}, imm64, 64'd0);
        chk({tag, ".fmt"}, 64'({f32, f64}), 64'd0);
        chk({tag, ".ill"}, 64'({il32, il64}), 64'd0);
        chk({tag, ".cnt"}, 64'({c32, c64, 14'd0, cc2}), 64'd0);
    endtask

    task automatic push(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = '0;
        step(); step();
        chk_reset("reset");
        rst_n = 1'b1;

        // Streaming decode, one result per cycle.
        push(32'hFFF00093); chk_out("addi_m1", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        push(32'h12345037); chk_out("lui",     32'h12345000, 64'h0000000012345000, 3'd4);
        push(32'h0040006F); chk_out("jal4",    32'h00000004, 64'h0000000000000004, 3'd5);
        push(32'h800000B7); chk_out("lui_neg", 32'h80000000, 64'hFFFFFFFF80000000, 3'd4);
        push(32'h03F09093); chk_out("slli63",  32'h0000001F, 64'h000000000000003F, 3'd6);
        push(32'h01F09093); chk_out("slli31",  32'h0000001F, 64'h000000000000001F, 3'd6);
        push(32'hFE000EE3); chk_out("beq_m4",  32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3);
        push(32'hFE20AC23); chk_out("sw_m8",   32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2);
        push(32'h3002D073); chk_out("csrrwi",  32'h00000005, 64'h0000000000000005, 3'd6);
        push(32'h002081B3); chk_out("add",     32'h00000000, 64'h0000000000000000, 3'd0);
        chk("add.ill", 64'({il32, il64}), 64'd0);

        // Illegal opcodes: two delivered, then three more to saturate the 2-bit counter.
        push(32'h0000007F); chk_out("ill1", 32'h0, 64'h0, 3'd7);
        chk("ill1.flag", 64'({il32, il64, ilc2}), 64'd7);
        chk("ill1.cnt", 64'(c32), 64'd0);
        push(32'h0000007F); chk_out("ill2", 32'h0, 64'h0, 3'd7);
        chk("ill2.cnt", 64'(c32), 64'd1);
        in_valid = 1'b0; step();
        chk("ill.cnt2_32", 64'(c32), 64'd2);
        chk("ill.cnt2_64", 64'(c64), 64'd2);
        chk("ill.cnt2_c2", 64'(cc2), 64'd2);
        chk("ill.drain", 64'(v32), 64'd0);
        push(32'h0000007F); push(32'h0000007F); push(32'h0000007F);
        in_valid = 1'b0; step();
        chk("sat.cnt32", 64'(c32), 64'd5);
        chk("sat.cnt_c2", 64'(cc2), 64'd3);

        // Backpressure: third push is refused, then FIFO order on release.
        out_ready = 1'b0;
        push(32'h00100093);
        chk("bp.rdy1", 64'(r32), 64'd1);
        push(32'h00200093);
        chk("bp.rdy_full", 64'({r32, r64, rc2}), 64'd0);
        chk_out("bp.a", 32'd1, 64'd1, 3'd1);
        push(32'h00300093);
        chk_out("bp.hold", 32'd1, 64'd1, 3'd1);
        chk("bp.rdy_hold", 64'(r32), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1; step();
        chk_out("bp.b", 32'd2, 64'd2, 3'd1);
        chk("bp.rdy_back", 64'(r32), 64'd1);
        step();
        chk("bp.empty", 64'({v32, v64}), 64'd0);

        // Flush while FULL with a concurrent valid input.
        out_ready = 1'b0;
        push(32'h00100093); push(32'h00200093);
        chk("fl.full", 64'(r32), 64'd0);
        flush = 1'b1; in_inst = 32'h00300093; in_valid = 1'b1; step();
        chk("fl.v", 64'({v32, v64, vc2}), 64'd0);
        chk("fl.rdy", 64'({r32, r64, rc2}), 64'd7);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk("fl.dropped", 64'({v32, v64}), 64'd0);

        // Reset mid-stream while FULL, then a clean restart.
        out_ready = 1'b0;
        push(32'h0000007F); push(32'h00200093);
        chk("rst.full", 64'(r32), 64'd0);
        rst_n = 1'b0; in_valid = 1'b0; step();
        chk_reset("rst_mid");
        rst_n = 1'b1; out_ready = 1'b1;
        push(32'h12345037); chk_out("rst.after", 32'h12345000, 64'h0000000012345000, 3'd4);

        // OP-IMM-32 is legal only for XLEN=64.
        push(32'h0010809B);
        chk("addiw.imm32", 64'(imm32), 64'd0);
        chk("addiw.fmt32", 64'(f32), 64'd7);
        chk("addiw.ill32", 64'(il32), 64'd1);
        chk("addiw.imm64", imm64, 64'd1);
        chk("addiw.fmt64", 64'(f64), 64'd1);
        chk("addiw.ill64", 64'(il64), 64'd0);
        in_valid = 1'b0; step();
        chk("addiw.cnt32", 64'(c32), 64'd1);
        chk("addiw.cnt64", 64'(c64), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, XLEN-parametrised RISC-V immediate generator with valid/ready handshaking on both sides. It sits between the instruction fetch buffer and the decode/issue stage. It extracts and sign- or zero-extends the immediate for every base-ISA format, including shift-amount and CSR zimm forms. It also tags each instruction with its format, flags unsupported opcodes, and absorbs downstream stalls in a two-entry skid buffer so `in_ready` is a register output.

## Interface
- `XLEN`, 32 — immediate/output width; legal values 32 and 64.
- `CNT_W`, 16 — width of the saturating illegal-opcode counter.

- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `flush`  in  1  — synchronous pipeline flush; drops all buffered entries.
- `in_valid`  in  1  — upstream instruction valid.
- `in_ready`  out  1  — block can accept; registered.
- `in_inst`  in  32  — raw instruction word.
- `out_valid`  out  1  — output entry valid.
- `out_ready`  in  1  — downstream accepts output.
- `out_imm`  out  XLEN  — generated immediate.
- `out_fmt`  out  3  — format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (zero-extended shamt/zimm), 7 illegal.
- `out_illegal`  out  1  — opcode not supported.
- `illegal_cnt`  out  CNT_W  — count of illegal instructions delivered; saturates at all-ones.

## Operation
- Decode is combinational on `in_inst`. The result is captured into the entry on handshake. Every path assigns `imm` and `fmt`, so no latches are inferred.
- Opcode 0010011 (OP-IMM):
  - funct3 001/101: fmt Z. imm = zero-extended `inst[24:20]` for XLEN=32, or `inst[25:20]` for XLEN=64.
  - Otherwise: fmt I, imm = sext(`inst[31:20]`).
- Opcodes 0000011, 1100111, 0001111: fmt I, imm = sext(`inst[31:20]`).
- Opcode 1110011:
  - funct3[2]=1: fmt Z, imm = zext(`inst[19:15]`).
  - Otherwise: fmt I, imm = sext(`inst[31:20]`).
- Opcode 0100011: fmt S, imm = sext({`inst[31:25]`,`inst[11:7]`}).
- Opcode 1100011: fmt B, imm = sext({`inst[31]`,`inst[7]`,`inst[30:25]`,`inst[11:8]`,1'b0}). Bit 0 is always 0.
- Opcodes 0110111 and 0010111: fmt U, imm = sext({`inst[31:12]`,12'b0}) to XLEN.
- Opcode 1101111: fmt J, imm = sext({`inst[31]`,`inst[19:12]`,`inst[20]`,`inst[30:21]`,1'b0}).
- Opcodes 0110011 and 0111011: fmt R, imm = 0.
- XLEN=64 only:
  - 0011011 (OP-IMM-32): funct3 001/101 gives fmt Z with 5-bit shamt; otherwise fmt I.
  - 0111011 is fmt R.
- Any other opcode, and for XLEN=32 the opcodes 0011011 and 0111011: fmt 7, `out_illegal`=1, imm = 0.
- Skid buffer holds two entries (main = output register, skid = overflow). Buffer states:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: main valid; in_ready=1.
  - FULL: main and skid valid; in_ready=0.
- Transitions (accept = in_valid&in_ready; pop = out_valid&out_ready):
  - EMPTY + accept → ONE.
  - ONE + accept & !pop → FULL, new entry goes to skid.
  - ONE + accept & pop → ONE, new entry goes to main.
  - ONE + pop & !accept → EMPTY.
  - FULL + pop → ONE, skid moves to main.
- Order is strictly FIFO.
- `illegal_cnt` increments on a pop with out_illegal=1 and holds at 2^CNT_W−1. It is not cleared by flush.

## Timing
- Latency: accept in cycle N gives out_valid in cycle N+1 if the buffer was EMPTY, or ONE with a pop in N.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready for cycle N+1 is computed from state at the end of cycle N. It depends on no input combinationally.
- While out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal hold stable.
- Reset (rst_n=0 at an edge), effective from the next cycle:
  - state EMPTY, out_valid=0, in_ready=1;
  - out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0.
  - Reset applies mid-stream too and discards all entries.
- flush=1 at an edge: state EMPTY, out_valid=0, in_ready=1.
  - A same-cycle accept is dropped.
  - A same-cycle pop still counts toward illegal_cnt.
- Reset has priority over flush; flush has priority over accept and pop.

## Test plan
- XLEN=32, inputs 0xFFF00093 (addi −1), 0x12345037 (lui), 0x0040006F (jal +4), each with out_ready=1 → one cycle later in turn: imm 0xFFFFFFFF fmt 1; 0x12345000 fmt 4; 0x00000004 fmt 5.
- XLEN=64:
  - 0x800000B7 → imm 0xFFFFFFFF80000000, fmt 4.
  - 0x03F09093 (slli 63) → imm 63, fmt 6.
  - XLEN=32 with 0x01F09093 → imm 31, fmt 6.
- Backpressure: out_ready=0, push 3 instructions back-to-back → in_ready drops after 2 accepts. Raise out_ready → outputs appear in order, then in_ready=1.
- Illegal: input 0x0000007F twice with pops → out_fmt 7, out_illegal 1, imm 0, illegal_cnt=2. With CNT_W=2, 5 illegals → count holds at 3.
- Flush while FULL, with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, input not delivered.
- Assert rst_n=0 mid-stream while FULL → next cycle all outputs at reset values. After release, the first accepted instruction is delivered correctly.
